imem_loader_responder: RTL and testbench
========================================

// Module: imem_loader_responder
// PURPOSE
//  Instruction-memory responder for the fetch stage: answers im_addr/im_rd fetches with instruction words.
//  Owns the program load sequence: accepts words over a valid/ready port, then pulses start_o into the fetch stage.
//  Pulses stop_o when fetch runs past the loaded program length.
//  Sits between the external program source (testbench/host) and the IF stage of the 16-bit pipeline.
// PARAMETERS
//  DATA_WIDTH  16  instruction word width
//  ADDR_WIDTH  8   fetch address width; memory depth = 2**ADDR_WIDTH words
// PORTS
//  clk            in   1             clock, all state updates on rising edge
//  rst_n          in   1             asynchronous active-low reset
//  load_valid_i   in   1             load word present
//  load_data_i    in   DATA_WIDTH    load word
//  load_last_i    in   1             current load word is the final program word
//  load_ready_o   out  1             loader accepts a word this cycle
//  reload_i       in   1             abandon RUN/HALT and return to IDLE for a new program
//  im_addr_i      in   ADDR_WIDTH    fetch address from IF stage
//  im_rd_i        in   1             fetch read enable
//  instr_o        out  DATA_WIDTH    fetched instruction (0 = NOP when not serving)
//  start_o        out  1             one-cycle start pulse to IF stage
//  stop_o         out  1             one-cycle stop pulse to IF stage
//  prog_len_o     out  ADDR_WIDTH+1  number of words loaded
//  full_o         out  1             load terminated by filling all 2**ADDR_WIDTH words
// BEHAVIOUR
//  - FSM states: IDLE -> LOAD -> START -> RUN -> HALT; reset state IDLE.
//  - Reset (rst_n low, async): state IDLE, wr_ptr 0, prog_len_o 0, start_o 0, stop_o 0, full_o 0, instr_o 0. Memory array not reset.
//  - load_ready_o = 1 in IDLE and LOAD only. Transfer = load_valid_i & load_ready_o.
//  - On a transfer: mem[wr_ptr] <= load_data_i; wr_ptr++; prog_len_o <= wr_ptr+1. IDLE moves to LOAD on the first transfer.
//  - Load end:
//    - A transfer with load_last_i = 1 -> START.
//    - A transfer at wr_ptr = 2**ADDR_WIDTH-1 -> START and full_o <= 1, whether or not load_last_i is set.
//    - wr_ptr never wraps.
//  - START lasts exactly one cycle with start_o = 1, then RUN. start_o is 0 in every other state.
//  - RUN, in-range fetch: when im_rd_i = 1 and {1'b0,im_addr_i} < prog_len_o, instr_o = mem[im_addr_i]. Combinational read, same-cycle.
//  - RUN, out-of-range fetch: when im_rd_i = 1 and {1'b0,im_addr_i} >= prog_len_o:
//    - instr_o = 0 that cycle;
//    - stop_o = 1 in the next cycle for exactly one cycle;
//    - state -> HALT.
//  - instr_o = 0 whenever im_rd_i = 0 or state != RUN.
//  - HALT: no further stop_o pulses. Fetches return 0.
//  - reload_i (RUN or HALT): next state IDLE; wr_ptr, prog_len_o and full_o cleared.
//    - reload_i wins over a same-cycle out-of-range fetch: no stop_o is issued.
//    - reload_i is ignored in IDLE, LOAD and START.
//  - load_valid_i is ignored outside IDLE/LOAD; no memory write occurs.
//  - Loading zero words is impossible: RUN always has prog_len_o >= 1.
// CONFIGURATION
//  IMEM_REG_OUT_EN defined:
//   - instr_o is registered: the word for the address presented in cycle N appears in cycle N+1.
//   - The range check uses the same registered timing, so stop_o moves one cycle later (N+2).
//   - instr_o resets to 0.
//  IMEM_REG_OUT_EN undefined: combinational read as above (default; matches the single-cycle IF fetch).
// TESTING
//  1. Load 3 words (0x1111, 0x2222, 0x3333 with last) -> start_o pulses 1 cycle after the last transfer; prog_len_o=3; fetch addr 0..2 returns words.
//  2. RUN: fetch addr 3 with im_rd_i=1 -> instr_o=0, stop_o=1 the next cycle only; a further addr-3 fetch gives no new stop_o.
//  3. Load 256 words without last -> full_o=1, START after word 255; a load_valid_i in RUN does not alter mem[0].
//  4. Assert rst_n low mid-LOAD after 2 words -> async clear of prog_len_o/start_o; re-load 1 word with last -> prog_len_o=1.
//  5. reload_i in HALT, then load 0xABCD with last -> start_o pulses again; addr 0 returns 0xABCD.
//  6. Fetch with im_rd_i=0 in RUN, or any fetch in IDLE -> instr_o=0; with IMEM_REG_OUT_EN, scenario 1 data lags the address by 1 cycle.

Source files
------------

// File: rtl/imem_loader_responder.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_responder
//  Description : Instruction-memory responder for the IF stage of the 16-bit
//                pipeline. Loads a program over a valid/ready port, pulses
//                start_o into fetch, answers im_addr_i/im_rd_i fetches and
//                pulses stop_o once when fetch runs past the program end.
//                Optional macro IMEM_REG_OUT_EN registers instr_o (one cycle
//                of read latency, stop_o one cycle later as well).
//  Revision    : 1.0  initial release
// ============================================================================
module imem_loader_responder #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    input  logic                  load_last_i,
    output logic                  load_ready_o,
    input  logic                  reload_i,
    input  logic [ADDR_WIDTH-1:0] im_addr_i,
    input  logic                  im_rd_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic                  start_o,
    output logic                  stop_o,
    output logic [ADDR_WIDTH:0]   prog_len_o,
    output logic                  full_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Index of the final memory slot; a transfer here ends the load.
    localparam logic [ADDR_WIDTH:0] LAST_SLOT = {1'b0, {ADDR_WIDTH{1'b1}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        RUN   = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic                  xfer;
    logic                  load_end;
    logic                  in_run;
    logic                  reload_hit;
    logic                  in_range;
    logic                  oor_hit;
    logic                  stop_src;
    logic [DATA_WIDTH-1:0] rd_word;

    // Handshake, load termination and fetch classification.
    always_comb begin
        load_ready_o = (state == IDLE) || (state == LOAD);
        xfer         = load_valid_i && load_ready_o;
        load_end     = load_last_i || (wr_ptr == LAST_SLOT);
        in_run       = (state == RUN);
        reload_hit   = reload_i && ((state == RUN) || (state == HALT));
        in_range     = ({1'b0, im_addr_i} < prog_len_o);
        oor_hit      = in_run && im_rd_i && !in_range;
        start_o      = (state == START);
    end

    // Same-cycle read path; NOP (0) whenever the fetch is not served.
    always_comb begin
        rd_word = '0;
        if (in_run && im_rd_i && in_range) begin
            rd_word = mem[im_addr_i];
        end
    end

    // Next-state logic; a reload takes priority over an out-of-range fetch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (xfer) begin
                    state_nxt = load_end ? START : LOAD;
                end
            end
            LOAD: begin
                if (xfer && load_end) begin
                    state_nxt = START;
                end
            end
            START: begin
                state_nxt = RUN;
            end
            RUN: begin
                if (reload_i) begin
                    state_nxt = IDLE;
                end else if (oor_hit) begin
                    state_nxt = HALT;
                end
            end
            HALT: begin
                if (reload_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Load bookkeeping: write pointer, program length and full flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            prog_len_o <= '0;
            full_o     <= 1'b0;
        end else if (reload_hit) begin
            wr_ptr     <= '0;
            prog_len_o <= '0;
            full_o     <= 1'b0;
        end else if (xfer) begin
            wr_ptr     <= wr_ptr + 1'b1;
            prog_len_o <= wr_ptr + 1'b1;
            if (wr_ptr == LAST_SLOT) begin
                full_o <= 1'b1;
            end
        end
    end

    // Program storage; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (xfer) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= load_data_i;
        end
    end

`ifdef IMEM_REG_OUT_EN
    logic [DATA_WIDTH-1:0] instr_q;
    logic                  oor_q;

    // Registered read: data and range verdict both lag the address by a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= '0;
            oor_q   <= 1'b0;
        end else begin
            instr_q <= rd_word;
            oor_q   <= oor_hit && !reload_i;
        end
    end

    // Stop request follows the registered range verdict.
    always_comb begin
        instr_o  = instr_q;
        stop_src = oor_q;
    end
`else
    // Combinational read; stop request comes straight from the fetch.
    always_comb begin
        instr_o  = rd_word;
        stop_src = oor_hit && !reload_i;
    end
`endif

    // One-cycle stop pulse; only a RUN-state overrun can raise it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stop_o <= 1'b0;
        end else begin
            stop_o <= stop_src;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader_responder
//  Description : Self-checking bench for imem_loader_responder (default build)
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_loader_responder;

    logic        clk;
    logic        rst_n;
    logic        load_valid_i;
    logic [15:0] load_data_i;
    logic        load_last_i;
    logic        load_ready_o;
    logic        reload_i;
    logic [7:0]  im_addr_i;
    logic        im_rd_i;
    logic [15:0] instr_o;
    logic        start_o;
    logic        stop_o;
    logic [8:0]  prog_len_o;
    logic        full_o;

    int n_checks = 0;
    int n_fail   = 0;

    imem_loader_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_valid_i (load_valid_i),
        .load_data_i  (load_data_i),
        .load_last_i  (load_last_i),
        .load_ready_o (load_ready_o),
        .reload_i     (reload_i),
        .im_addr_i    (im_addr_i),
        .im_rd_i      (im_rd_i),
        .instr_o      (instr_o),
        .start_o      (start_o),
        .stop_o       (stop_o),
        .prog_len_o   (prog_len_o),
        .full_o       (full_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [15:0] data;
        logic        last;
        logic        reload;
        logic [7:0]  addr;
        logic        rd;
        logic [15:0] e_instr;
        logic        e_start;
        logic        e_stop;
        logic        e_ready;
        logic [8:0]  e_len;
        logic        e_full;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [15:0] d, input logic l,
                                input logic rl, input logic [7:0] a, input logic r,
                                input logic [15:0] ei, input logic es, input logic ep,
                                input logic er, input logic [8:0] en, input logic ef);
        vec_t x;
        x.valid = v;  x.data = d;  x.last = l;  x.reload = rl;
        x.addr = a;   x.rd = r;    x.e_instr = ei;
        x.e_start = es; x.e_stop = ep; x.e_ready = er; x.e_len = en; x.e_full = ef;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        load_valid_i = 1'b0; load_data_i = '0; load_last_i = 1'b0;
        reload_i = 1'b0; im_addr_i = '0; im_rd_i = 1'b0;
    endtask

    // Apply inputs just after a rising edge; sample on the following falling edge.
    task automatic step(input logic v, input logic [15:0] d, input logic l,
                        input logic rl, input logic [7:0] a, input logic r);
        @(posedge clk);
        #1;
        load_valid_i = v; load_data_i = d; load_last_i = l;
        reload_i = rl; im_addr_i = a; im_rd_i = r;
        @(negedge clk);
    endtask

    vec_t vecs[$];

    initial begin
        idle_inputs();
        rst_n = 1'b0;

        //             v  data      l  rl addr  rd  instr    st sp rdy len   full
        vecs.push_back(mk(0, 16'h0000, 0, 0, 8'd0, 1, 16'h0000, 0, 0, 1, 9'd0, 0)); // IDLE fetch
        vecs.push_back(mk(1, 16'h1111, 0, 0, 8'd0, 0, 16'h0000, 0, 0, 1, 9'd0, 0));
        vecs.push_back(mk(1, 16'h2222, 0, 0, 8'd0, 0, 16'h0000, 0, 0, 1, 9'd1, 0));
        vecs.push_back(mk(1, 16'h3333, 1, 0, 8'd0, 0, 16'h0000, 0, 0, 1, 9'd2, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 8'd0, 1, 16'h0000, 1, 0, 0, 9'd3, 0)); // START
        vecs.push_back(mk(0, 16'h0000, 0, 0, 8'd0, 1, 16'h1111, 0, 0, 0, 9'd3, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 8'd1, 1, 16'h2222, 0, 0, 0, 9'd3, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 8'd2, 1, 16'h3333, 0, 0, 0, 9'd3, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 8'd0, 0, 16'h0000, 0, 0, 0, 9'd3, 0)); // rd=0
        vecs.push_back(mk(0, 16'h0000, 0, 0, 8'd3, 1, 16'h0000, 0, 0, 0, 9'd3, 0)); // overrun
        vecs.push_back(mk(0, 16'h0000, 0, 0, 8'd3, 1, 16'h0000, 0, 1, 0, 9'd3, 0)); // stop pulse
        vecs.push_back(mk(0, 16'h0000, 0, 0, 8'd3, 1, 16'h0000, 0, 0, 0, 9'd3, 0)); // no repeat
        vecs.push_back(mk(0, 16'h0000, 0, 0, 8'd0, 1, 16'h0000, 0, 0, 0, 9'd3, 0)); // HALT fetch
        vecs.push_back(mk(0, 16'h0000, 0, 1, 8'd0, 0, 16'h0000, 0, 0, 0, 9'd3, 0)); // reload
        vecs.push_back(mk(1, 16'hABCD, 1, 0, 8'd0, 0, 16'h0000, 0, 0, 1, 9'd0, 0));
        vecs.push_back(mk(1, 16'h5555, 0, 0, 8'd0, 0, 16'h0000, 1, 0, 0, 9'd1, 0)); // ignored
        vecs.push_back(mk(0, 16'h0000, 0, 0, 8'd0, 1, 16'hABCD, 0, 0, 0, 9'd1, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 1, 8'd1, 1, 16'h0000, 0, 0, 0, 9'd1, 0)); // reload+oor
        vecs.push_back(mk(0, 16'h0000, 0, 0, 8'd0, 0, 16'h0000, 0, 0, 1, 9'd0, 0)); // no stop

        // Reset state
        #12;
        chk("reset_len",   prog_len_o, 0);
        chk("reset_start", start_o, 0);
        chk("reset_stop",  stop_o, 0);
        chk("reset_full",  full_o, 0);
        chk("reset_instr", instr_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: scenarios 1, 2, 5, 6 and reload-vs-overrun priority
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].valid, vecs[i].data, vecs[i].last, vecs[i].reload,
                 vecs[i].addr, vecs[i].rd);
            chk($sformatf("v%0d_instr", i), instr_o,      vecs[i].e_instr);
            chk($sformatf("v%0d_start", i), start_o,      vecs[i].e_start);
            chk($sformatf("v%0d_stop",  i), stop_o,       vecs[i].e_stop);
            chk($sformatf("v%0d_ready", i), load_ready_o, vecs[i].e_ready);
            chk($sformatf("v%0d_len",   i), prog_len_o,   vecs[i].e_len);
            chk($sformatf("v%0d_full",  i), full_o,       vecs[i].e_full);
        end

        // Scenario 3: fill all 256 slots without last
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 16'hA500 | 16'(i), 1'b0, 1'b0, 8'd0, 1'b0);
            chk("fill_ready", load_ready_o, 1);
            chk("fill_start_low", start_o, 0);
        end
        step(1'b1, 16'hDEAD, 1'b0, 1'b0, 8'd0, 1'b0);   // in START
        chk("fill_full",  full_o, 1);
        chk("fill_len",   prog_len_o, 256);
        chk("fill_start", start_o, 1);
        chk("fill_ready_low", load_ready_o, 0);
        step(1'b1, 16'hDEAD, 1'b0, 1'b0, 8'd0, 1'b0);   // in RUN, ignored
        chk("run_start_low", start_o, 0);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 8'd0, 1'b1);
        chk("full_mem0", instr_o, 16'hA500);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 8'd255, 1'b1);
        chk("full_mem255", instr_o, 16'hA5FF);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 8'd1, 1'b1);
        chk("full_no_stop", stop_o, 0);
        chk("full_mem1", instr_o, 16'hA501);
        step(1'b0, 16'h0000, 1'b0, 1'b1, 8'd0, 1'b0);   // reload from RUN
        step(1'b0, 16'h0000, 1'b0, 1'b0, 8'd0, 1'b0);
        chk("reload_full_clr", full_o, 0);
        chk("reload_len_clr",  prog_len_o, 0);
        chk("reload_ready",    load_ready_o, 1);

        // Scenario 4: async reset mid-load
        step(1'b1, 16'h0101, 1'b0, 1'b0, 8'd0, 1'b0);
        step(1'b1, 16'h0202, 1'b0, 1'b0, 8'd0, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 8'd0, 1'b0);
        chk("pre_rst_len", prog_len_o, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_len",   prog_len_o, 0);
        chk("async_start", start_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 16'h0BEE, 1'b1, 1'b0, 8'd0, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 8'd0, 1'b0);
        chk("reload1_len",   prog_len_o, 1);
        chk("reload1_start", start_o, 1);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 8'd0, 1'b1);
        chk("reload1_mem0",  instr_o, 16'h0BEE);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 8'd1, 1'b1);
        chk("reload1_oor",   instr_o, 0);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 8'd0, 1'b0);
        chk("reload1_stop",  stop_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
